fadd_align: RTL and testbench

Front end of the 16-bit half-precision adder. Takes two IEEE-754 binary16 operands and an add/sub opcode through a valid/ready handshake, then unpacks, compares, swaps and aligns them. It produces the pre-normalisation bundle that `fadd_norm` consumes: `cal_frac`, `temp_exp`, `sign`, `is_nan`, `is_inf`, `inf_nan_frac` and `rm`. It is a two-stage pipeline that holds data correctly under backpressure.

---
 rtl/fp16_pkg.sv | 49 ++++
 rtl/fp16_sticky_shr.sv | 23 ++
 rtl/fadd_align.sv | 163 ++++++++++++++++
 tb/tb_fadd_align.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp16_pkg.sv
// Shared binary16 definitions for the half-precision adder datapath.
package fp16_pkg;

    localparam int EXP_W   = 5;
    localparam int FRAC_W  = 10;
    localparam int CAL_W   = 15;
    localparam int SIG_W   = 14;   // {hidden, frac[9:0], guard, round, sticky}
    localparam int SHAMT_W = 5;

    localparam logic [EXP_W-1:0]  EXP_MAX   = 5'h1F;
    localparam logic [FRAC_W-1:0] QNAN_FRAC = 10'h200;

    typedef enum logic [1:0] {
        RM_RNE = 2'b00,
        RM_RDN = 2'b01,
        RM_RUP = 2'b10,
        RM_RTZ = 2'b11
    } rm_e;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
    } fp16_t;

    // Everything stage 2 needs to align and combine the two significands.
    typedef struct packed {
        logic [SIG_W-1:0]   big_sig;
        logic [SIG_W-1:0]   small_sig;
        logic [SHAMT_W-1:0] shamt;
        logic [EXP_W-1:0]   temp_exp;
        logic               sign;
        logic               eff_sub;
        logic               is_nan;
        logic               is_inf;
        logic [1:0]         rm;
    } align_s1_t;

    // Denormals and zeros sit at effective exponent 1.
    function automatic logic [EXP_W-1:0] eff_exp(input logic [EXP_W-1:0] e);
        return (e == '0) ? 5'd1 : e;
    endfunction

    // Significand with hidden bit and three empty guard/round/sticky slots.
    function automatic logic [SIG_W-1:0] sig14(input fp16_t x);
        return {(x.exp != '0), x.frac, 3'b000};
    endfunction

endpackage

// File: rtl/fp16_sticky_shr.sv
// Combinational right shifter for the 14-bit significand; every bit shifted
// out past bit 0 is ORed back into bit 0 as the sticky bit.
module fp16_sticky_shr
    import fp16_pkg::*;
(
    input  logic [SIG_W-1:0]   data_i,
    input  logic [SHAMT_W-1:0] shamt_i,
    output logic [SIG_W-1:0]   data_o
);

    logic [2*SIG_W-1:0] wide;

    // Shift through a double-width window so dropped bits collect in the low half.
    always_comb begin
        // NOTE: data_o gets a default before the override, so no latch is inferred.
        wide   = {data_i, {SIG_W{1'b0}}} >> shamt_i;
        data_o = wide[2*SIG_W-1:SIG_W] | {{(SIG_W-1){1'b0}}, |wide[SIG_W-1:0]};
        if (shamt_i >= SHAMT_W'(SIG_W)) begin
            data_o = {{(SIG_W-1){1'b0}}, |data_i};
        end
    end

endmodule

// File: rtl/fadd_align.sv
// Front end of the binary16 adder: unpack, classify, swap (S1) then align and
// add/subtract (S2), with a two-deep valid/ready pipeline.
module fadd_align
    import fp16_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [15:0]       a,
    input  logic [15:0]       b,
    input  logic              sub,
    input  logic [1:0]        rm_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CAL_W-1:0]  cal_frac,
    output logic [EXP_W-1:0]  temp_exp,
    output logic              sign,
    output logic              is_nan,
    output logic              is_inf,
    output logic [FRAC_W-1:0] inf_nan_frac,
    output logic [1:0]        rm
);

    // ---------------------------------------------------------------- handshake
    logic s1_valid_q;
    logic out_valid_q;
    logic s2_adv;
    logic s1_adv;
    logic accept;

    assign s2_adv   = !out_valid_q || out_ready;
    assign s1_adv   = !s1_valid_q || s2_adv;
    assign in_ready = s1_adv;
    assign accept   = in_valid && in_ready;

    // ------------------------------------------------------------------ stage 1
    fp16_t     op_a;
    fp16_t     op_b;
    fp16_t     big_op;
    fp16_t     lit_op;
    logic      a_nan, b_nan, a_inf, b_inf;
    logic      a_is_big;
    align_s1_t s1_d;
    align_s1_t s1_q;

    // Unpack, classify specials and order the operands by magnitude.
    always_comb begin
        s1_d     = '0;
        op_a     = a;
        op_b     = {b[15] ^ sub, b[14:0]};

        a_nan    = (op_a.exp == EXP_MAX) && (op_a.frac != '0);
        b_nan    = (op_b.exp == EXP_MAX) && (op_b.frac != '0);
        a_inf    = (op_a.exp == EXP_MAX) && (op_a.frac == '0);
        b_inf    = (op_b.exp == EXP_MAX) && (op_b.frac == '0);

        // Ties keep A as the big operand.
        a_is_big = {op_a.exp, op_a.frac} >= {op_b.exp, op_b.frac};
        big_op   = a_is_big ? op_a : op_b;
        lit_op   = a_is_big ? op_b : op_a;

        s1_d.big_sig   = sig14(big_op);
        s1_d.small_sig = sig14(lit_op);
        s1_d.shamt     = eff_exp(big_op.exp) - eff_exp(lit_op.exp);
        s1_d.temp_exp  = big_op.exp;
        s1_d.eff_sub   = op_a.sign ^ op_b.sign;
        s1_d.is_nan    = a_nan || b_nan || (a_inf && b_inf && s1_d.eff_sub);
        s1_d.is_inf    = !s1_d.is_nan && (a_inf || b_inf);
        if (s1_d.is_inf) begin
            s1_d.sign = a_inf ? op_a.sign : op_b.sign;
        end else begin
            s1_d.sign = big_op.sign;
        end
        s1_d.rm        = rm_in;
    end

    // Stage 1 register: capture the prepared operands on accept.
    always_ff @(posedge clk) begin
        // NOTE: nonblocking assignments so every register samples pre-edge values.
        if (rst) begin
            s1_valid_q <= 1'b0;
            // NOTE: payload registers are reset as well, so outputs read 0 (not X) after reset.
            s1_q       <= '0;
        end else begin
            if (s1_adv) begin
                s1_valid_q <= in_valid;
            end
            if (accept) begin
                s1_q <= s1_d;
            end
        end
    end

    // ------------------------------------------------------------------ stage 2
    logic [SIG_W-1:0]  small_aligned;
    logic [CAL_W-1:0]  cal_frac_d, cal_frac_q;
    logic [EXP_W-1:0]  temp_exp_d, temp_exp_q;
    logic              sign_d, sign_q;
    logic              is_nan_d, is_nan_q;
    logic              is_inf_d, is_inf_q;
    logic [FRAC_W-1:0] inf_nan_frac_d, inf_nan_frac_q;
    logic [1:0]        rm_d, rm_q;

    fp16_sticky_shr u_shr (
        .data_i  (s1_q.small_sig),
        .shamt_i (s1_q.shamt),
        .data_o  (small_aligned)
    );

    // Combine significands; an exact-zero difference takes its sign from the rounding mode.
    always_comb begin
        if (s1_q.eff_sub) begin
            cal_frac_d = {1'b0, s1_q.big_sig} - {1'b0, small_aligned};
        end else begin
            cal_frac_d = {1'b0, s1_q.big_sig} + {1'b0, small_aligned};
        end
        temp_exp_d     = s1_q.temp_exp;
        is_nan_d       = s1_q.is_nan;
        is_inf_d       = s1_q.is_inf;
        inf_nan_frac_d = s1_q.is_nan ? QNAN_FRAC : '0;
        rm_d           = s1_q.rm;
        sign_d         = s1_q.sign;
        if (s1_q.eff_sub && !s1_q.is_nan && !s1_q.is_inf && (cal_frac_d == '0)) begin
            sign_d = (s1_q.rm == RM_RDN);
        end
    end

    // Stage 2 register: output bundle, held while downstream stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q    <= 1'b0;
            cal_frac_q     <= '0;
            temp_exp_q     <= '0;
            sign_q         <= 1'b0;
            is_nan_q       <= 1'b0;
            is_inf_q       <= 1'b0;
            inf_nan_frac_q <= '0;
            rm_q           <= '0;
        end else if (s2_adv) begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                cal_frac_q     <= cal_frac_d;
                temp_exp_q     <= temp_exp_d;
                sign_q         <= sign_d;
                is_nan_q       <= is_nan_d;
                is_inf_q       <= is_inf_d;
                inf_nan_frac_q <= inf_nan_frac_d;
                rm_q           <= rm_d;
            end
        end
    end

    assign out_valid    = out_valid_q;
    assign cal_frac     = cal_frac_q;
    assign temp_exp     = temp_exp_q;
    assign sign         = sign_q;
    assign is_nan       = is_nan_q;
    assign is_inf       = is_inf_q;
    assign inf_nan_frac = inf_nan_frac_q;
    assign rm           = rm_q;

endmodule

// File: tb/tb_fadd_align.sv
// Directed self-checking bench for fadd_align.
module tb_fadd_align;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic [1:0]  rm_in;
    logic        out_valid;
    logic        out_ready;
    logic [14:0] cal_frac;
    logic [4:0]  temp_exp;
    logic        sign;
    logic        is_nan;
    logic        is_inf;
    logic [9:0]  inf_nan_frac;
    logic [1:0]  rm;

    int checks = 0;
    int errors = 0;
    logic early_valid;

    always #5 clk = ~clk;

    fadd_align dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .a            (a),
        .b            (b),
        .sub          (sub),
        .rm_in        (rm_in),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .cal_frac     (cal_frac),
        .temp_exp     (temp_exp),
        .sign         (sign),
        .is_nan       (is_nan),
        .is_inf       (is_inf),
        .inf_nan_frac (inf_nan_frac),
        .rm           (rm)
    );

    // Observed bundle: {cal_frac, temp_exp, sign, is_nan, is_inf, inf_nan_frac, rm}
    logic [34:0] obs;
    assign obs = {cal_frac, temp_exp, sign, is_nan, is_inf, inf_nan_frac, rm};

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic        sub;
        logic [1:0]  rm;
        logic [14:0] cal;
        logic [4:0]  ex;
        logic        sg;
        logic        nan;
        logic        inf;
    } vec_t;

    vec_t vt [14];

    function automatic logic [34:0] exp_obs(input vec_t v);
        return {v.cal, v.ex, v.sg, v.nan, v.inf, (v.nan ? 10'h200 : 10'h000), v.rm};
    endfunction

    // cal_frac/temp_exp are don't-care for specials; sign too for NaN.
    function automatic logic [34:0] care_mask(input vec_t v);
        if (v.nan) return {15'h0, 5'h0, 1'b0, 1'b1, 1'b1, 10'h3FF, 2'b11};
        if (v.inf) return {15'h0, 5'h0, 1'b1, 1'b1, 1'b1, 10'h3FF, 2'b11};
        return '1;
    endfunction

    task automatic init_vectors();
        //            a         b         sub   rm     cal_frac  exp    sg    nan   inf
        vt[0]  = '{16'h3C00, 16'h3C00, 1'b0, 2'b00, 15'h4000, 5'd15, 1'b0, 1'b0, 1'b0}; // 1+1
        vt[1]  = '{16'h3C00, 16'h3C00, 1'b1, 2'b01, 15'h0000, 5'd15, 1'b1, 1'b0, 1'b0}; // 1-1 RDN
        vt[2]  = '{16'h3C00, 16'h3C00, 1'b1, 2'b00, 15'h0000, 5'd15, 1'b0, 1'b0, 1'b0}; // 1-1 RNE
        vt[3]  = '{16'h3C00, 16'h0400, 1'b0, 2'b00, 15'h2001, 5'd15, 1'b0, 1'b0, 1'b0}; // d=14
        vt[4]  = '{16'h3C00, 16'h2C01, 1'b0, 2'b00, 15'h2201, 5'd15, 1'b0, 1'b0, 1'b0}; // d=4 sticky
        vt[5]  = '{16'h3800, 16'h3C00, 1'b1, 2'b00, 15'h1000, 5'd15, 1'b1, 1'b0, 1'b0}; // 0.5-1 swap
        vt[6]  = '{16'h0001, 16'h0001, 1'b0, 2'b00, 15'h0010, 5'd0,  1'b0, 1'b0, 1'b0}; // denormals
        vt[7]  = '{16'h7C00, 16'h7C00, 1'b1, 2'b00, 15'h0000, 5'd31, 1'b0, 1'b1, 1'b0}; // inf-inf
        vt[8]  = '{16'hFC00, 16'h3C00, 1'b0, 2'b00, 15'h0000, 5'd31, 1'b1, 1'b0, 1'b1}; // -inf+1
        vt[9]  = '{16'h7E00, 16'h3C00, 1'b0, 2'b00, 15'h0000, 5'd31, 1'b0, 1'b1, 1'b0}; // NaN in
        vt[10] = '{16'h3C00, 16'h7C00, 1'b1, 2'b00, 15'h0000, 5'd31, 1'b1, 1'b0, 1'b1}; // 1-inf
        vt[11] = '{16'h0000, 16'h0000, 1'b0, 2'b11, 15'h0000, 5'd0,  1'b0, 1'b0, 1'b0}; // 0+0 RTZ
        vt[12] = '{16'hBC00, 16'h3C00, 1'b0, 2'b10, 15'h0000, 5'd15, 1'b0, 1'b0, 1'b0}; // -1+1 RUP
        vt[13] = '{16'hBC00, 16'h3C00, 1'b0, 2'b01, 15'h0000, 5'd15, 1'b1, 1'b0, 1'b0}; // -1+1 RDN
    endtask

    task automatic drive(input vec_t v);
        a     = v.a;
        b     = v.b;
        sub   = v.sub;
        rm_in = v.rm;
    endtask

    // Push one bundle into an empty pipeline and wait out the 2-cycle latency.
    task automatic run_one(input vec_t v);
        @(posedge clk); #1;
        drive(v);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid    = 1'b0;
        early_valid = out_valid;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; sub = 1'b0; rm_in = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || obs !== 35'h0) begin
            errors++;
            $display("FAIL reset_outputs: out_valid=%b bundle=%h, want 0 and 0", out_valid, obs);
        end
        rst = 1'b0;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_add();
        int idx [5] = '{0, 3, 4, 6, 11};
        foreach (idx[k]) begin
            run_one(vt[idx[k]]);
            checks++;
            if (early_valid !== 1'b0 || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL add_latency[%0d]: valid after 1 cycle=%b, after 2=%b, want 0 then 1",
                         idx[k], early_valid, out_valid);
            end
            checks++;
            if ((obs & care_mask(vt[idx[k]])) !== (exp_obs(vt[idx[k]]) & care_mask(vt[idx[k]]))) begin
                errors++;
                $display("FAIL add[%0d]: got %h want %h", idx[k], obs, exp_obs(vt[idx[k]]));
            end
        end
    endtask

    task automatic test_sub();
        int idx [5] = '{1, 2, 5, 12, 13};
        foreach (idx[k]) begin
            run_one(vt[idx[k]]);
            checks++;
            if (out_valid !== 1'b1 ||
                (obs & care_mask(vt[idx[k]])) !== (exp_obs(vt[idx[k]]) & care_mask(vt[idx[k]]))) begin
                errors++;
                $display("FAIL sub[%0d]: valid=%b got %h want %h", idx[k], out_valid, obs,
                         exp_obs(vt[idx[k]]));
            end
        end
    endtask

    task automatic test_specials();
        int idx [4] = '{7, 8, 9, 10};
        foreach (idx[k]) begin
            run_one(vt[idx[k]]);
            checks++;
            if (out_valid !== 1'b1 ||
                (obs & care_mask(vt[idx[k]])) !== (exp_obs(vt[idx[k]]) & care_mask(vt[idx[k]]))) begin
                errors++;
                $display("FAIL special[%0d]: valid=%b got %h want %h (masked)", idx[k], out_valid,
                         obs & care_mask(vt[idx[k]]), exp_obs(vt[idx[k]]) & care_mask(vt[idx[k]]));
            end
        end
    endtask

    task automatic test_back_to_back();
        int idx [3] = '{0, 3, 4};
        @(posedge clk); #1;
        out_ready = 1'b1;
        drive(vt[idx[0]]);
        in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            if (k + 1 < 3) drive(vt[idx[k+1]]);
            else           in_valid = 1'b0;
            if (k >= 1) begin
                checks++;
                if (out_valid !== 1'b1 || obs !== exp_obs(vt[idx[k-1]])) begin
                    errors++;
                    $display("FAIL b2b[%0d]: valid=%b got %h want %h", k - 1, out_valid, obs,
                             exp_obs(vt[idx[k-1]]));
                end
            end
        end
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_drain: out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_backpressure();
        int   idx [4] = '{0, 3, 4, 5};
        int   sent = 0;
        int   recv = 0;
        int   cyc  = 0;
        logic fire_in;
        logic fire_out;
        logic dup;
        @(posedge clk); #1;
        out_ready = 1'b0;
        drive(vt[idx[0]]);
        in_valid = 1'b1;
        while (recv < 4 && cyc < 40) begin
            @(negedge clk);
            fire_in  = in_valid & in_ready;
            fire_out = out_valid & out_ready;
            if (cyc == 2) begin
                checks++;
                if (in_ready !== 1'b0 || sent != 2) begin
                    errors++;
                    $display("FAIL bp_in_ready: in_ready=%b after %0d accepts, want 0 after 2",
                             in_ready, sent);
                end
            end
            if (cyc >= 2 && cyc <= 4) begin
                checks++;
                if (out_valid !== 1'b1 || obs !== exp_obs(vt[idx[0]])) begin
                    errors++;
                    $display("FAIL bp_hold[%0d]: valid=%b got %h want %h", cyc, out_valid, obs,
                             exp_obs(vt[idx[0]]));
                end
            end
            if (fire_out) begin
                checks++;
                if (obs !== exp_obs(vt[idx[recv]])) begin
                    errors++;
                    $display("FAIL bp_order[%0d]: got %h want %h", recv, obs, exp_obs(vt[idx[recv]]));
                end
                recv++;
            end
            @(posedge clk); #1;
            if (fire_in) begin
                sent++;
                if (sent < 4) drive(vt[idx[sent]]);
                else          in_valid = 1'b0;
            end
            if (cyc == 4) out_ready = 1'b1;
            cyc++;
        end
        checks++;
        if (recv != 4 || sent != 4) begin
            errors++;
            $display("FAIL bp_count: sent=%0d received=%0d want 4 and 4", sent, recv);
        end
        dup = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) dup = 1'b1;
        end
        checks++;
        if (dup !== 1'b0) begin
            errors++;
            $display("FAIL bp_extra: extra out_valid seen=%b want 0", dup);
        end
    endtask

    task automatic test_reset_midstream();
        logic stale;
        @(posedge clk); #1;
        out_ready = 1'b1;
        drive(vt[0]);
        in_valid = 1'b1;
        @(posedge clk); #1;
        drive(vt[3]);
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_setup: out_valid=%b want 1 before reset", out_valid);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || obs !== 35'h0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid: out_valid=%b bundle=%h in_ready=%b want 0, 0, 1",
                     out_valid, obs, in_ready);
        end
        stale = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) stale = 1'b1;
        end
        checks++;
        if (stale !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_stale: stale bundle seen=%b want 0", stale);
        end
    endtask

    initial begin
        init_vectors();
        test_reset();
        test_add();
        test_sub();
        test_specials();
        test_back_to_back();
        test_backpressure();
        test_reset_midstream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
